// File: rtl/timer_pkg.sv
// Shared constants for the timer prescaler.
// Base codes select the clk_out[0] divisor.
package timer_pkg;

    localparam int CNT_W_DEF    = 8;
    localparam int NUM_TAPS_DEF = 4;
    localparam int BASE_W       = 2;

    localparam logic [BASE_W-1:0] BASE_DIV2  = 2'd0;
    localparam logic [BASE_W-1:0] BASE_DIV4  = 2'd1;
    localparam logic [BASE_W-1:0] BASE_DIV8  = 2'd2;
    localparam logic [BASE_W-1:0] BASE_DIV16 = 2'd3;

endpackage

// File: rtl/timer_prescaler_if.sv
// Control and tap bundle between the timer core
// and the prescaler.
interface timer_prescaler_if
    import timer_pkg::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_DEF
);

    logic                en;
    logic                clr;
    logic [BASE_W-1:0]   base_sel;
    logic [NUM_TAPS-1:0] clk_out;
    logic                wrap;
    logic [BASE_W-1:0]   base_act;

    modport master (
        output en,
        output clr,
        output base_sel,
        input  clk_out,
        input  wrap,
        input  base_act
    );

    modport slave (
        input  en,
        input  clr,
        input  base_sel,
        output clk_out,
        output wrap,
        output base_act
    );

endinterface

// File: rtl/timer_prescaler.sv
// Free-running prescaler: one counter, four square-wave
// taps whose base exponent only changes at wrap or clear.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NUM_TAPS = NUM_TAPS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    timer_prescaler_if.slave  bus
);

    logic [CNT_W-1:0]    r_cnt;
    logic [BASE_W-1:0]   r_base;
    logic                r_wrap;
    logic                w_full;
    logic [NUM_TAPS-1:0] w_s0;
    logic [NUM_TAPS-1:0] w_s1;
    logic [NUM_TAPS-1:0] w_s2;
    logic [NUM_TAPS-1:0] w_s3;
    logic [NUM_TAPS-1:0] w_tap;

    assign w_full = (r_cnt == {CNT_W{1'b1}});

    // Counter, applied base and wrap pulse; the base
    // is only reloaded when the counter returns to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_base <= BASE_DIV2;
            r_wrap <= 1'b0;
        end else if (bus.clr) begin
            r_cnt  <= '0;
            r_base <= bus.base_sel;
            r_wrap <= 1'b0;
        end else if (bus.en && w_full) begin
            r_cnt  <= '0;
            r_base <= bus.base_sel;
            r_wrap <= 1'b1;
        end else if (bus.en) begin
            r_cnt  <= r_cnt + 1'b1;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign w_s0 = r_cnt[NUM_TAPS-1:0];
    assign w_s1 = r_cnt[NUM_TAPS:1];
    assign w_s2 = r_cnt[NUM_TAPS+1:2];
    assign w_s3 = r_cnt[NUM_TAPS+2:3];

    // Tap mux: pick adjacent counter bits offset by base.
    always_comb begin
        w_tap = w_s0;
        unique case (r_base)
            BASE_DIV2:  w_tap = w_s0;
            BASE_DIV4:  w_tap = w_s1;
            BASE_DIV8:  w_tap = w_s2;
            BASE_DIV16: w_tap = w_s3;
        endcase
    end

    assign bus.clk_out  = w_tap;
    assign bus.wrap     = r_wrap;
    assign bus.base_act = r_base;

endmodule

// File: tb/tb_timer_prescaler.sv
// Randomized and directed bench for timer_prescaler
// against an arithmetic reference model.
module tb_timer_prescaler;

    localparam int CW = 8;
    localparam int NT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    timer_prescaler_if #(.NUM_TAPS(NT)) bus ();

    timer_prescaler #(
        .CNT_W   (CW),
        .NUM_TAPS(NT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_cnt  = 0;
    int m_base = 0;
    int m_wrap = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int m_taps();
        int v = 0;
        for (int k = 0; k < NT; k++)
            if (((m_cnt >> (k + m_base)) & 1) == 1)
                v |= (1 << k);
        return v;
    endfunction

    // Compare DUT against the model every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("clk_out", int'(bus.clk_out), m_taps());
            chk("wrap", int'(bus.wrap), m_wrap);
            chk("base_act", int'(bus.base_act), m_base);
        end
    end

    task automatic step(input bit e, input bit c, input int bs);
        bus.en       = e;
        bus.clr      = c;
        bus.base_sel = bs[1:0];
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_base = 0; m_wrap = 0;
        end else if (c) begin
            m_cnt = 0; m_base = bs; m_wrap = 0;
        end else if (e && m_cnt == (1 << CW) - 1) begin
            m_cnt = 0; m_base = bs; m_wrap = 1;
        end else if (e) begin
            m_cnt = m_cnt + 1; m_wrap = 0;
        end else begin
            m_wrap = 0;
        end
        #1;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.clr = 1'b0;
        bus.base_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_clk_out", int'(bus.clk_out), 0);
        chk("reset_wrap", int'(bus.wrap), 0);
        chk("reset_base", int'(bus.base_act), 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Base 0 waveform.
        step(1, 1, 0);
        for (int i = 1; i <= 32; i++) begin
            step(1, 0, 0);
            chk("b0_tap0", int'(bus.clk_out[0]), i % 2);
            chk("b0_tap3", int'(bus.clk_out[3]),
                ((i % 16) >= 8) ? 1 : 0);
        end

        // Wrap pulse spacing.
        step(1, 1, 0);
        for (int i = 1; i <= 770; i++) begin
            step(1, 0, 0);
            if (i % 256 == 0 || i % 256 == 1)
                chk("wrap_pulse", int'(bus.wrap),
                    (i % 256 == 0) ? 1 : 0);
        end

        // Deferred base change.
        step(1, 1, 0);
        for (int i = 0; i < 'h40; i++) step(1, 0, 0);
        step(1, 0, 2);
        chk("defer_hold", int'(bus.base_act), 0);
        for (int i = 0; i < 190; i++) step(1, 0, 2);
        chk("defer_pre_base", int'(bus.base_act), 0);
        chk("defer_pre_tap0", int'(bus.clk_out[0]), 1);
        step(1, 0, 2);
        chk("defer_wrap", int'(bus.wrap), 1);
        chk("defer_base", int'(bus.base_act), 2);
        chk("defer_tap0_lo", int'(bus.clk_out[0]), 0);
        repeat (3) step(1, 0, 1);
        chk("defer_tap0_3", int'(bus.clk_out[0]), 0);
        step(1, 0, 1);
        chk("defer_tap0_4", int'(bus.clk_out[0]), 1);

        // Enable freeze at cnt=5.
        step(1, 1, 0);
        repeat (5) step(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 3);
            chk("freeze_taps", int'(bus.clk_out), 5);
            chk("freeze_wrap", int'(bus.wrap), 0);
        end
        step(1, 0, 0);
        chk("freeze_resume", int'(bus.clk_out), 6);

        // Clear beats wrap at all-ones.
        step(1, 1, 0);
        repeat (255) step(1, 0, 0);
        chk("clr_pre_taps", int'(bus.clk_out), 15);
        step(1, 1, 3);
        chk("clr_wrap", int'(bus.wrap), 0);
        chk("clr_base", int'(bus.base_act), 3);
        chk("clr_taps", int'(bus.clk_out), 0);

        // Async reset mid-count.
        step(1, 1, 2);
        repeat ('h37) step(1, 0, 2);
        chk("pre_rst_base", int'(bus.base_act), 2);
        #2;
        chk_on = 1'b0;
        rst = 1'b1;
        m_cnt = 0; m_base = 0; m_wrap = 0;
        #1;
        chk("rst_async_taps", int'(bus.clk_out), 0);
        chk("rst_async_wrap", int'(bus.wrap), 0);
        chk("rst_async_base", int'(bus.base_act), 0);
        chk_on = 1'b1;
        step(1, 0, 3);
        #2;
        rst = 1'b0;
        step(1, 0, 3);
        chk("rst_resume", int'(bus.clk_out), 1);
        chk("rst_resume_base", int'(bus.base_act), 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 9) < 8,
                 $urandom_range(0, 199) == 0,
                 int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
